// File: rtl/mc_pwm_bank.sv
// Bank of CHANNELS on/off PWM generators behind one mc register window; MC_PWM_IRQ_EN adds status/mask/irq.
// Writes land on the strobe edge; rdata and pwm_out/irq are registered (1 cycle); strobes are never stalled.
module mc_pwm_bank #(
    parameter int                   CHANNELS  = 4,
    parameter int                   WIDTH     = 16,
    parameter int                   ADD_WIDTH = 6,
    parameter logic [ADD_WIDTH-1:0] BASE_ADD  = 6'h18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_stb,
    input  logic                 rd_stb,
    input  logic [ADD_WIDTH-1:0] add,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
`ifdef MC_PWM_IRQ_EN
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 irq
`else
    output logic [CHANNELS-1:0]  pwm_out
`endif
);

    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    function automatic logic [ADD_WIDTH-1:0] reg_add(input int offset);
        return ADD_WIDTH'(int'(BASE_ADD) + offset);
    endfunction

    logic [CHANNELS-1:0] en;
    logic [WIDTH-1:0]    on_reg  [CHANNELS];
    logic [WIDTH-1:0]    off_reg [CHANNELS];
    logic [WIDTH-1:0]    on_sh   [CHANNELS];
    logic [WIDTH-1:0]    off_sh  [CHANNELS];
    logic [WIDTH:0]      cnt     [CHANNELS];
    logic [WIDTH:0]      period  [CHANNELS];

    logic                ctrl_hit;
    logic [CHANNELS-1:0] on_hit;
    logic [CHANNELS-1:0] off_hit;
    logic [CHANNELS-1:0] restart;
    logic [CHANNELS-1:0] period_end;
    logic [CHANNELS-1:0] load;
    logic [WIDTH-1:0]    rd_val;

`ifdef MC_PWM_IRQ_EN
    logic [CHANNELS-1:0] mask;
    logic [CHANNELS-1:0] status;
    logic [CHANNELS-1:0] status_clr;
    logic                status_hit;
`endif

    always_comb begin
        ctrl_hit   = (add == BASE_ADD);
        on_hit     = '0;
        off_hit    = '0;
        restart    = '0;
        period_end = '0;
        load       = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            on_hit[n]  = (add == reg_add(1 + 2*n));
            off_hit[n] = (add == reg_add(2 + 2*n));
            // Period is one bit wider than the registers so on+off never wraps.
            period[n]     = {1'b0, on_sh[n]} + {1'b0, off_sh[n]};
            restart[n]    = wr_stb && ctrl_hit && wdata[CHANNELS+n];
            period_end[n] = en[n] && (period[n] != '0) && (cnt[n] == period[n] - ONE);
            load[n]       = !en[n] || restart[n] || (period[n] == '0) || period_end[n];
        end
    end

`ifdef MC_PWM_IRQ_EN
    always_comb begin
        status_hit = (add == reg_add(1 + 2*CHANNELS));
        status_clr = (wr_stb && status_hit) ? wdata[CHANNELS-1:0] : '0;
    end
`endif

    always_comb begin
        rd_val = '0;
        if (ctrl_hit) begin
            rd_val[CHANNELS-1:0] = en;
`ifdef MC_PWM_IRQ_EN
            rd_val[2*CHANNELS +: CHANNELS] = mask;
`endif
        end
        for (int n = 0; n < CHANNELS; n++) begin
            if (on_hit[n])  rd_val = on_reg[n];
            if (off_hit[n]) rd_val = off_reg[n];
        end
`ifdef MC_PWM_IRQ_EN
        if (status_hit) rd_val[CHANNELS-1:0] = status;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            en      <= '0;
            rdata   <= '0;
            pwm_out <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                on_reg[n]  <= '0;
                off_reg[n] <= '0;
                on_sh[n]   <= '0;
                off_sh[n]  <= '0;
                cnt[n]     <= '0;
            end
`ifdef MC_PWM_IRQ_EN
            mask   <= '0;
            status <= '0;
            irq    <= 1'b0;
`endif
        end else begin
            if (wr_stb && ctrl_hit) begin
                en <= wdata[CHANNELS-1:0];
`ifdef MC_PWM_IRQ_EN
                mask <= wdata[2*CHANNELS +: CHANNELS];
`endif
            end
            // A colliding write wins; the read result is dropped.
            if (rd_stb && !wr_stb) rdata <= rd_val;

            for (int n = 0; n < CHANNELS; n++) begin
                if (wr_stb && on_hit[n])  on_reg[n]  <= wdata;
                if (wr_stb && off_hit[n]) off_reg[n] <= wdata;
                if (load[n]) begin
                    cnt[n]    <= '0;
                    on_sh[n]  <= on_reg[n];
                    off_sh[n] <= off_reg[n];
                end else begin
                    cnt[n] <= cnt[n] + ONE;
                end
                pwm_out[n] <= en[n] && (cnt[n] < {1'b0, on_sh[n]});
            end

`ifdef MC_PWM_IRQ_EN
            // Set has priority over a same-cycle write-1-to-clear.
            status <= (status & ~status_clr) | period_end;
            irq    <= |(status & mask);
`endif
        end
    end

endmodule
